div_mod_seq: RTL

DIV_MOD_SEQ -- requirements
Module: div_mod_seq

---
 rtl/div_mod_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/div_mod_seq.sv
// div_mod_seq: multi-cycle signed divider returning either the quotient or the
// remainder of a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor.
// The core is a restoring shift-subtract divider that works on operand magnitudes.
// Signs are applied afterwards, with truncation toward zero.
// The quotient saturates to the signed RESULT_W range.
// Every operation takes DIVIDEND_W+2 cycles from the accepting edge to the result
// pulse, whatever the operand values are.

module div_mod_seq #(
   parameter  int DIVIDEND_W = 32,
   parameter  int DIVISOR_W  = 16,
   localparam int RESULT_W   = DIVISOR_W + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [DIVIDEND_W-1:0] dividend,
   input  logic signed [DIVISOR_W-1:0]  divisor,
   input  logic                        mode,
   input  logic                        valid_input,
   output logic                        busy,
   output logic                        valid_output,
   output logic signed [RESULT_W-1:0]   final_output,
   output logic                        div_by_zero,
   output logic                        overflow
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   // Quotient magnitude limits, widened by one bit so that the comparison is safe
   // even when both operands have the same width.
   localparam logic [DIVIDEND_W:0] NEG_LIM = (DIVIDEND_W + 1)'(1) << DIVISOR_W;
   localparam logic [DIVIDEND_W:0] POS_LIM = NEG_LIM - (DIVIDEND_W + 1)'(1);

   localparam logic [RESULT_W-1:0] POS_SAT = {1'b0, {DIVISOR_W{1'b1}}};
   localparam logic [RESULT_W-1:0] NEG_SAT = {1'b1, {DIVISOR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic                  neg_dvd_q, neg_dvd_d;
   logic                  neg_dvs_q, neg_dvs_d;
   logic                  mode_q, mode_d;
   logic [RESULT_W-1:0]   final_output_q, final_output_d;
   logic                  div_by_zero_q, div_by_zero_d;
   logic                  overflow_q, overflow_d;

   logic [DIVIDEND_W-1:0] dvd_raw;
   logic [DIVISOR_W-1:0]  dvs_raw;
   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W:0]    trial_diff;
   logic [DIVIDEND_W:0]   q_ext;
   logic [RESULT_W-1:0]   q_small;
   logic [RESULT_W-1:0]   rem_ext;
   logic                  neg_q;

   assign dvd_raw = dividend;
   assign dvs_raw = divisor;

   // Datapath helpers: the trial subtraction for one restoring step, and the
   // widened quotient/remainder magnitudes that the sign fix-up uses.
   always_comb begin
      trial      = {rem_q, quo_q[DIVIDEND_W-1]};
      trial_diff = trial - {1'b0, dvs_q};
      q_ext      = {1'b0, quo_q};
      q_small    = q_ext[RESULT_W-1:0];
      rem_ext    = {1'b0, rem_q};
      neg_q      = neg_dvd_q ^ neg_dvs_q;
   end

   // Next-state and datapath control: accept in IDLE, iterate in CALC,
   // apply signs and flags in FIX, then announce the result from DONE.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      quo_d          = quo_q;
      rem_d          = rem_q;
      dvs_d          = dvs_q;
      neg_dvd_d      = neg_dvd_q;
      neg_dvs_d      = neg_dvs_q;
      mode_d         = mode_q;
      final_output_d = final_output_q;
      div_by_zero_d  = div_by_zero_q;
      overflow_d     = overflow_q;

      case (state_q)
         IDLE: begin
            if (valid_input) begin
               neg_dvd_d = dvd_raw[DIVIDEND_W-1];
               neg_dvs_d = dvs_raw[DIVISOR_W-1];
               quo_d     = dvd_raw[DIVIDEND_W-1] ? -dvd_raw : dvd_raw;
               dvs_d     = dvs_raw[DIVISOR_W-1] ? -dvs_raw : dvs_raw;
               mode_d    = mode;
               rem_d     = '0;
               count_d   = CNT_W'(DIVIDEND_W);
               state_d   = CALC;
            end
         end

         CALC: begin
            if (count_q != '0) begin
               if (trial >= {1'b0, dvs_q}) begin
                  rem_d = trial_diff[DIVISOR_W-1:0];
                  quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
               end else begin
                  rem_d = trial[DIVISOR_W-1:0];
                  quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
               end
               count_d = count_q - CNT_W'(1);
            end else begin
               state_d = FIX;
            end
         end

         FIX: begin
            state_d = DONE;
            if (dvs_q == '0) begin
               final_output_d = '0;
               div_by_zero_d  = 1'b1;
               overflow_d     = 1'b0;
            end else if (mode_q) begin
               final_output_d = neg_dvd_q ? -rem_ext : rem_ext;
               div_by_zero_d  = 1'b0;
               overflow_d     = 1'b0;
            end else if (!neg_q && (q_ext > POS_LIM)) begin
               final_output_d = POS_SAT;
               div_by_zero_d  = 1'b0;
               overflow_d     = 1'b1;
            end else if (neg_q && (q_ext > NEG_LIM)) begin
               final_output_d = NEG_SAT;
               div_by_zero_d  = 1'b0;
               overflow_d     = 1'b1;
            end else begin
               final_output_d = neg_q ? -q_small : q_small;
               div_by_zero_d  = 1'b0;
               overflow_d     = 1'b0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         count_q        <= '0;
         quo_q          <= '0;
         rem_q          <= '0;
         dvs_q          <= '0;
         neg_dvd_q      <= 1'b0;
         neg_dvs_q      <= 1'b0;
         mode_q         <= 1'b0;
         final_output_q <= '0;
         div_by_zero_q  <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         quo_q          <= quo_d;
         rem_q          <= rem_d;
         dvs_q          <= dvs_d;
         neg_dvd_q      <= neg_dvd_d;
         neg_dvs_q      <= neg_dvs_d;
         mode_q         <= mode_d;
         final_output_q <= final_output_d;
         div_by_zero_q  <= div_by_zero_d;
         overflow_q     <= overflow_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign valid_output = (state_q == DONE);
   assign final_output = final_output_q;
   assign div_by_zero  = div_by_zero_q;
   assign overflow     = overflow_q;

endmodule
